// File: rtl/vga_text_ctrl.sv
// Text-mode character layer: 80x30 character buffer, pixel-to-cell mapping and glyph colour output.
// Optional blinking cursor overlay is enabled by defining CURSOR_EN.
module vga_text_ctrl #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [7:0] BLANK_CHAR = 8'h20
`ifdef CURSOR_EN
    , parameter int       BLINK_CYCLES = 12500000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_in,
    input  logic [9:0]  px,
    input  logic [9:0]  py,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic [7:0]  ascii,
    output logic [9:0]  x_over,
    output logic [9:0]  y_over,
    input  logic [23:0] glyph_data,
`ifdef CURSOR_EN
    input  logic        cur_en,
    input  logic [11:0] cur_addr,
`endif
    output logic        de_out,
    output logic [23:0] pix_rgb
);

    localparam logic [11:0] CELLS     = 12'(COLS * ROWS);
    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
    localparam logic [11:0] COLS_W    = 12'(COLS);
    localparam logic [10:0] PX_LIMIT  = 11'(COLS * 8);
    localparam logic [10:0] PY_LIMIT  = 11'(ROWS * 16);

    typedef enum logic {CLEAR, IDLE} state_e;

    state_e      state_q;
    logic [11:0] clrCnt_q;
    logic        clrBusy_q;
    logic        wrReady_q;

    logic [7:0]  mem [COLS*ROWS];
    logic        ramWe;
    logic [11:0] ramWaddr;
    logic [7:0]  ramWdata;

    logic        inArea;
    logic [11:0] rdAddr;
    logic [7:0]  ascii_q;
    logic [9:0]  xOver_q;
    logic [9:0]  yOver_q;
    logic        inArea_q;
    logic        de_q;
    logic        deOut_q;
    logic [23:0] pixRgb_q;
    logic        cursorHit;

    // Clear sweeps one cell per cycle; user writes are only honoured once idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clrCnt_q  <= '0;
            clrBusy_q <= 1'b1;
            wrReady_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clrCnt_q == LAST_CELL) begin
                        state_q   <= IDLE;
                        clrCnt_q  <= '0;
                        clrBusy_q <= 1'b0;
                        wrReady_q <= 1'b1;
                    end else begin
                        clrCnt_q <= clrCnt_q + 12'd1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state_q   <= CLEAR;
                        clrCnt_q  <= '0;
                        clrBusy_q <= 1'b1;
                        wrReady_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ramWe    = 1'b0;
        ramWaddr = clrCnt_q;
        ramWdata = BLANK_CHAR;
        if (state_q == CLEAR) begin
            ramWe = 1'b1;
        end else if (wrReady_q && wr_en && (wr_addr < CELLS)) begin
            ramWe    = 1'b1;
            ramWaddr = wr_addr;
            ramWdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem[ramWaddr] <= ramWdata;
        end
    end

    // Off-screen pixels read cell 0 so the RAM index always stays in range.
    always_comb begin
        inArea = de_in && ({1'b0, px} < PX_LIMIT) && ({1'b0, py} < PY_LIMIT);
        rdAddr = inArea ? ({6'b0, py[9:4]} * COLS_W + {5'b0, px[9:3]}) : 12'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ascii_q  <= '0;
            xOver_q  <= '0;
            yOver_q  <= '0;
            inArea_q <= 1'b0;
            de_q     <= 1'b0;
            deOut_q  <= 1'b0;
            pixRgb_q <= '0;
        end else begin
            ascii_q  <= inArea ? mem[rdAddr] : BLANK_CHAR;
            xOver_q  <= {7'b0, px[2:0]};
            yOver_q  <= {6'b0, py[3:0]};
            inArea_q <= inArea;
            de_q     <= de_in;
            deOut_q  <= de_q;
            if (inArea_q) begin
                pixRgb_q <= cursorHit ? ~glyph_data : glyph_data;
            end else if (de_q) begin
                pixRgb_q <= 24'hFFFFFF;
            end else begin
                pixRgb_q <= 24'h000000;
            end
        end
    end

`ifdef CURSOR_EN
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] blinkCnt_q;
    logic               phase_q;
    logic [11:0]        cellAddr_q;

    // Cell index travels with S1 so the cursor match lines up with the glyph colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blinkCnt_q <= '0;
            phase_q    <= 1'b0;
            cellAddr_q <= '0;
        end else begin
            cellAddr_q <= rdAddr;
            if (blinkCnt_q == BLINK_LAST) begin
                blinkCnt_q <= '0;
                phase_q    <= ~phase_q;
            end else begin
                blinkCnt_q <= blinkCnt_q + 1'b1;
            end
        end
    end

    assign cursorHit = cur_en && phase_q && (cellAddr_q == cur_addr);
`else
    assign cursorHit = 1'b0;
`endif

    assign wr_ready = wrReady_q;
    assign clr_busy = clrBusy_q;
    assign ascii    = ascii_q;
    assign x_over   = xOver_q;
    assign y_over   = yOver_q;
    assign de_out   = deOut_q;
    assign pix_rgb  = pixRgb_q;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed self-checking bench for vga_text_ctrl: clear sequencing, writes, pixel pipeline and area edges.
// With CURSOR_EN defined it also exercises the blinking cursor at a short blink period.
module tb_vga_text_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de_in;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        clr_req;
    logic        clr_busy;
    logic [7:0]  ascii;
    logic [9:0]  x_over;
    logic [9:0]  y_over;
    logic [23:0] glyph_data;
    logic        de_out;
    logic [23:0] pix_rgb;
`ifdef CURSOR_EN
    logic        cur_en;
    logic [11:0] cur_addr;
`endif

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    // Stand-in glyph lookup: colour encodes character and in-cell position.
    assign glyph_data = {ascii, x_over[7:0], y_over[7:0]};

    vga_text_ctrl #(
        .COLS(80),
        .ROWS(30),
        .BLANK_CHAR(8'h20)
`ifdef CURSOR_EN
        , .BLINK_CYCLES(4)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .de_in(de_in),
        .px(px),
        .py(py),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .clr_req(clr_req),
        .clr_busy(clr_busy),
        .ascii(ascii),
        .x_over(x_over),
        .y_over(y_over),
        .glyph_data(glyph_data),
`ifdef CURSOR_EN
        .cur_en(cur_en),
        .cur_addr(cur_addr),
`endif
        .de_out(de_out),
        .pix_rgb(pix_rgb)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic de, input logic [9:0] x, input logic [9:0] y);
        de_in = de;
        px    = x;
        py    = y;
    endtask

    task automatic writeCell(input logic [11:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic readCell(input string tag, input logic [9:0] x, input logic [9:0] y, input logic [7:0] expected);
        applyStimulus(1'b1, x, y);
        tick();
        checkOutput(tag, {24'b0, ascii}, {24'b0, expected});
        applyStimulus(1'b0, 10'd0, 10'd0);
    endtask

    // Counts clock edges until clr_busy drops, optionally poking a write or clr_req on the way.
    task automatic runClear(input string tag, input int dropWriteAt, input int reqAt);
        int cycles = 0;
        int readyWhileBusy = 0;
        while (clr_busy === 1'b1 && cycles < 3000) begin
            tick();
            cycles++;
            wr_en   = (cycles == dropWriteAt);
            wr_addr = 12'd5;
            wr_data = 8'h55;
            clr_req = (cycles == reqAt);
            if (clr_busy && wr_ready) readyWhileBusy++;
        end
        wr_en   = 1'b0;
        clr_req = 1'b0;
        checkOutput({tag, " busy cycles"}, cycles, 32'd2400);
        checkOutput({tag, " ready while busy"}, readyWhileBusy, 32'd0);
        checkOutput({tag, " wr_ready after"}, {31'b0, wr_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
`ifdef CURSOR_EN
        cur_en   = 1'b0;
        cur_addr = '0;
`endif
        applyStimulus(1'b1, 10'd11, 10'd18);
        repeat (3) tick();

        checkOutput("reset ascii",    {24'b0, ascii},    32'h0);
        checkOutput("reset x_over",   {22'b0, x_over},   32'h0);
        checkOutput("reset y_over",   {22'b0, y_over},   32'h0);
        checkOutput("reset de_out",   {31'b0, de_out},   32'h0);
        checkOutput("reset pix_rgb",  {8'b0, pix_rgb},   32'h0);
        checkOutput("reset wr_ready", {31'b0, wr_ready}, 32'h0);
        checkOutput("reset clr_busy", {31'b0, clr_busy}, 32'h1);

        applyStimulus(1'b0, 10'd0, 10'd0);
        rst_n = 1'b1;
        runClear("initial clear", 100, 1000);

        readCell("cell 0 blank", 10'd0, 10'd0, 8'h20);
        readCell("cell 5 write during clear dropped", 10'd40, 10'd0, 8'h20);
        readCell("cell 2399 blank", 10'd632, 10'd464, 8'h20);

        writeCell(12'd81, 8'h41);
        applyStimulus(1'b1, 10'd11, 10'd18);
        tick();
        checkOutput("cell 81 ascii",  {24'b0, ascii},  32'h41);
        checkOutput("cell 81 x_over", {22'b0, x_over}, 32'd3);
        checkOutput("cell 81 y_over", {22'b0, y_over}, 32'd2);
        checkOutput("de_out latency", {31'b0, de_out}, 32'h0);
        applyStimulus(1'b0, 10'd0, 10'd0);
        tick();
        checkOutput("cell 81 de_out",  {31'b0, de_out}, 32'h1);
        checkOutput("cell 81 pix_rgb", {8'b0, pix_rgb}, 32'h410302);
        tick();
        checkOutput("blanked de_out",  {31'b0, de_out}, 32'h0);
        checkOutput("blanked pix_rgb", {8'b0, pix_rgb}, 32'h0);

        writeCell(12'd2400, 8'h42);
        readCell("cell 0 after bad addr", 10'd0, 10'd0, 8'h20);
        readCell("cell 2399 after bad addr", 10'd632, 10'd464, 8'h20);

        applyStimulus(1'b1, 10'd0, 10'd0);
        wr_en   = 1'b1;
        wr_addr = 12'd0;
        wr_data = 8'h43;
        tick();
        wr_en = 1'b0;
        checkOutput("same-cycle read old", {24'b0, ascii}, 32'h20);
        tick();
        checkOutput("next-cycle read new", {24'b0, ascii}, 32'h43);

        applyStimulus(1'b1, 10'd100, 10'd479);
        tick();
        checkOutput("bottom row x_over", {22'b0, x_over}, 32'd4);
        checkOutput("bottom row y_over", {22'b0, y_over}, 32'd15);
        applyStimulus(1'b0, 10'd0, 10'd0);
        tick();
        checkOutput("bottom row pix_rgb", {8'b0, pix_rgb}, 32'h20040F);
        checkOutput("bottom row de_out",  {31'b0, de_out}, 32'h1);
        tick();
        checkOutput("de low pix_rgb", {8'b0, pix_rgb}, 32'h0);

        applyStimulus(1'b1, 10'd640, 10'd0);
        tick();
        checkOutput("px 640 ascii blank", {24'b0, ascii}, 32'h20);
        applyStimulus(1'b1, 10'd639, 10'd479);
        tick();
        checkOutput("px 640 pix white", {8'b0, pix_rgb}, 32'hFFFFFF);
        checkOutput("px 640 de_out",    {31'b0, de_out}, 32'h1);
        applyStimulus(1'b1, 10'd0, 10'd480);
        tick();
        checkOutput("last cell pix_rgb", {8'b0, pix_rgb}, 32'h20070F);
        checkOutput("py 480 ascii blank", {24'b0, ascii}, 32'h20);
        applyStimulus(1'b0, 10'd0, 10'd0);
        tick();
        checkOutput("py 480 pix white", {8'b0, pix_rgb}, 32'hFFFFFF);
        tick();
        checkOutput("trailing pix black", {8'b0, pix_rgb}, 32'h0);

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        checkOutput("clr_req busy",  {31'b0, clr_busy}, 32'h1);
        checkOutput("clr_req ready", {31'b0, wr_ready}, 32'h0);
        applyStimulus(1'b1, 10'd700, 10'd0);
        repeat (999) tick();
        checkOutput("mid-clear pix white", {8'b0, pix_rgb}, 32'hFFFFFF);
        checkOutput("mid-clear de_out",    {31'b0, de_out}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort pix_rgb",  {8'b0, pix_rgb},   32'h0);
        checkOutput("abort de_out",   {31'b0, de_out},   32'h0);
        checkOutput("abort ascii",    {24'b0, ascii},    32'h0);
        checkOutput("abort clr_busy", {31'b0, clr_busy}, 32'h1);
        checkOutput("abort wr_ready", {31'b0, wr_ready}, 32'h0);
        applyStimulus(1'b0, 10'd0, 10'd0);
        tick();
        rst_n = 1'b1;
        runClear("restarted clear", -1, 500);
        readCell("cell 0 after restart", 10'd0, 10'd0, 8'h20);
        readCell("cell 81 after restart", 10'd11, 10'd18, 8'h20);

`ifdef CURSOR_EN
        begin
            logic [23:0] prevPix;
            logic [23:0] startPix;
            logic        changed;
            cur_en   = 1'b1;
            cur_addr = 12'd0;
            applyStimulus(1'b1, 10'd0, 10'd0);
            tick();
            tick();
            prevPix = pix_rgb;
            changed = 1'b0;
            for (int i = 0; i < 10 && !changed; i++) begin
                tick();
                if (pix_rgb !== prevPix) changed = 1'b1;
            end
            checkOutput("cursor toggle seen", {31'b0, changed}, 32'h1);
            startPix = pix_rgb;
            checkOutput("cursor colour valid",
                        {31'b0, (startPix == 24'h200000) || (startPix == 24'hDFFFFF)}, 32'h1);
            for (int k = 1; k < 12; k++) begin
                tick();
                checkOutput("cursor blink", {8'b0, pix_rgb},
                            {8'b0, (((k / 4) % 2) == 0) ? startPix : ~startPix});
            end
            cur_en = 1'b0;
            applyStimulus(1'b0, 10'd0, 10'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
